// File: rtl/bus_rr_arbiter.sv
// Two-master shared bus with round-robin arbitration, optional hold limit,
// parametrised slave address map and a registered read-return path.
module bus_rr_arbiter #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 16,
    parameter int N_SLAVE     = 4,
    parameter int REGION_BITS = 5,
    parameter int MAX_HOLD    = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [1:0]                  m_req,
    input  logic [1:0]                  m_wr,
    input  logic [ADDR_W-1:0]           m0_addr,
    input  logic [ADDR_W-1:0]           m1_addr,
    input  logic [DATA_W-1:0]           m0_dout,
    input  logic [DATA_W-1:0]           m1_dout,
    input  logic [N_SLAVE*DATA_W-1:0]   s_dout,
    output logic [1:0]                  m_grant,
    output logic [DATA_W-1:0]           m_din,
    output logic [1:0]                  m_rvalid,
    output logic [1:0]                  m_err,
    output logic [N_SLAVE-1:0]          s_sel,
    output logic                        s_wr,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_din
);

    localparam int RGN_W  = ADDR_W - REGION_BITS;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam bit HOLD_EN = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [1:0]          grant_r;
    logic                last_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                hold_force_s;

    logic                owner_s;
    logic                xfer_s;
    logic                wr_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wdata_s;
    logic [RGN_W-1:0]    region_s;
    logic [N_SLAVE-1:0]  sel_s;
    logic                err_s;

    logic [1:0]          rvalid_r;
    logic [1:0]          err_r;
    logic [N_SLAVE-1:0]  sel_r;
    logic [DATA_W-1:0]   din_s;

    assign hold_force_s = HOLD_EN && (hold_cnt_r == HOLD_LAST);

    // Next-state logic: round-robin tie-break on last_r, forced handover at hold limit
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (m_req == 2'b11)  next_state_s = last_r ? G0 : G1;
                else if (m_req[0])   next_state_s = G0;
                else if (m_req[1])   next_state_s = G1;
                else                 next_state_s = IDLE;
            end
            G0: begin
                if (!m_req[0])                    next_state_s = m_req[1] ? G1 : IDLE;
                else if (hold_force_s && m_req[1]) next_state_s = G1;
                else                              next_state_s = G0;
            end
            G1: begin
                if (!m_req[1])                    next_state_s = m_req[0] ? G0 : IDLE;
                else if (hold_force_s && m_req[0]) next_state_s = G0;
                else                              next_state_s = G1;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Arbiter state, registered grant, last owner and hold counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            grant_r    <= 2'b00;
            last_r     <= 1'b1;
            hold_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            grant_r <= {next_state_s == G1, next_state_s == G0};
            if (next_state_s == G0)      last_r <= 1'b0;
            else if (next_state_s == G1) last_r <= 1'b1;
            else                         last_r <= last_r;
            // Saturating at the limit makes a late request from the other master hand over at once
            if (next_state_s != state_r)                          hold_cnt_r <= '0;
            else if (state_r != IDLE && hold_cnt_r != HOLD_LAST)  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            else                                                  hold_cnt_r <= hold_cnt_r;
        end
    end

    assign m_grant = grant_r;
    assign owner_s = grant_r[1];
    assign xfer_s  = |(grant_r & m_req);

    // Owner path mux, zero outside a transfer cycle
    always_comb begin
        addr_s  = '0;
        wdata_s = '0;
        wr_s    = 1'b0;
        if (xfer_s) begin
            addr_s  = owner_s ? m1_addr : m0_addr;
            wdata_s = owner_s ? m1_dout : m0_dout;
            wr_s    = m_wr[owner_s];
        end else begin
            addr_s  = '0;
            wdata_s = '0;
            wr_s    = 1'b0;
        end
    end

    assign region_s = addr_s[ADDR_W-1:REGION_BITS];

    // Region decode; an out-of-map region leaves every select low
    always_comb begin
        sel_s = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            sel_s[k] = xfer_s && (region_s == RGN_W'(k));
        end
    end

    assign err_s  = xfer_s && !(|sel_s);
    assign s_sel  = sel_s;
    assign s_wr   = wr_s && (|sel_s);
    assign s_addr = addr_s;
    assign s_din  = wdata_s;

    // Read-return capture: one-cycle rvalid/err pulses toward the transfer owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
            sel_r    <= '0;
        end else begin
            rvalid_r <= grant_r & {2{xfer_s && !wr_s}};
            err_r    <= grant_r & {2{err_s}};
            sel_r    <= (xfer_s && !wr_s) ? sel_s : '0;
        end
    end

    // Return data mux from the captured select; zero on decode error
    always_comb begin
        din_s = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            din_s = din_s | (s_dout[k*DATA_W +: DATA_W] & {DATA_W{sel_r[k]}});
        end
    end

    assign m_din    = din_s;
    assign m_rvalid = rvalid_r;
    assign m_err    = err_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: unlimited-hold instance plus a MAX_HOLD=4 instance
// sharing the same stimulus.
module tb_bus_rr_arbiter;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 16;
    localparam int N_SLAVE = 4;

    logic                       clk;
    logic                       reset_n;
    logic [1:0]                 m_req;
    logic [1:0]                 m_wr;
    logic [ADDR_W-1:0]          m0_addr, m1_addr;
    logic [DATA_W-1:0]          m0_dout, m1_dout;
    logic [N_SLAVE*DATA_W-1:0]  s_dout;

    logic [1:0]                 m_grant, m_rvalid, m_err;
    logic [DATA_W-1:0]          m_din;
    logic [N_SLAVE-1:0]         s_sel;
    logic                       s_wr;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_din;

    logic [1:0]                 h_grant, h_rvalid, h_err;
    logic [DATA_W-1:0]          h_din;
    logic [N_SLAVE-1:0]         h_sel;
    logic                       h_wr;
    logic [ADDR_W-1:0]          h_addr;
    logic [DATA_W-1:0]          h_sdin;

    int checks;
    int failures;

    bus_rr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVE(N_SLAVE), .REGION_BITS(5), .MAX_HOLD(0)) dut (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
        .s_dout(s_dout), .m_grant(m_grant), .m_din(m_din), .m_rvalid(m_rvalid),
        .m_err(m_err), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din)
    );

    bus_rr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVE(N_SLAVE), .REGION_BITS(5), .MAX_HOLD(4)) dut_h (
        .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_wr(m_wr),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
        .s_dout(s_dout), .m_grant(h_grant), .m_din(h_din), .m_rvalid(h_rvalid),
        .m_err(h_err), .s_sel(h_sel), .s_wr(h_wr), .s_addr(h_addr), .s_din(h_sdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_slaves();
        s_dout = '0;
        s_dout[0*DATA_W +: DATA_W] = 64'h0000_0000_0000_1111;
        s_dout[1*DATA_W +: DATA_W] = 64'h0000_0000_0000_2222;
        s_dout[2*DATA_W +: DATA_W] = 64'h0000_0000_0000_A5A5;
        s_dout[3*DATA_W +: DATA_W] = 64'h0000_0000_0000_3333;
    endtask

    task automatic clear_inputs();
        m_req   = 2'b00;
        m_wr    = 2'b00;
        m0_addr = 16'h0000;
        m1_addr = 16'h0000;
        m0_dout = 64'h0;
        m1_dout = 64'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        m_req   = 2'($urandom);
        m_wr    = 2'($urandom);
        m0_addr = 16'($urandom);
        m1_addr = 16'($urandom);
        m0_dout = {32'($urandom), 32'($urandom)};
        m1_dout = {32'($urandom), 32'($urandom)};
        for (int k = 0; k < N_SLAVE; k++) s_dout[k*DATA_W +: DATA_W] = {32'($urandom), 32'($urandom)};
        reset_n = 1'b0;
        #1;
        checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL rst_grant got=%b exp=%b", m_grant, 2'b00); end
        checks++; if (m_din !== 64'h0) begin failures++; $display("FAIL rst_din got=%h exp=%h", m_din, 64'h0); end
        checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL rst_rvalid got=%b exp=%b", m_rvalid, 2'b00); end
        checks++; if (m_err !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=%b", m_err, 2'b00); end
        checks++; if (s_sel !== 4'b0000) begin failures++; $display("FAIL rst_sel got=%b exp=%b", s_sel, 4'b0000); end
        checks++; if (s_wr !== 1'b0) begin failures++; $display("FAIL rst_swr got=%b exp=%b", s_wr, 1'b0); end
        checks++; if (s_addr !== 16'h0) begin failures++; $display("FAIL rst_saddr got=%h exp=%h", s_addr, 16'h0); end
        checks++; if (s_din !== 64'h0) begin failures++; $display("FAIL rst_sdin got=%h exp=%h", s_din, 64'h0); end
        @(negedge clk);
        checks++; if (h_grant !== 2'b00) begin failures++; $display("FAIL rst_hold_grant got=%b exp=%b", h_grant, 2'b00); end
        clear_inputs();
        set_slaves();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        m_req = 2'b01; m_wr = 2'b00; m0_addr = 16'h0041;
        @(negedge clk);
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL rd_grant got=%b exp=%b", m_grant, 2'b01); end
        checks++; if (s_sel !== 4'b0100) begin failures++; $display("FAIL rd_sel got=%b exp=%b", s_sel, 4'b0100); end
        checks++; if (s_addr !== 16'h0041) begin failures++; $display("FAIL rd_saddr got=%h exp=%h", s_addr, 16'h0041); end
        checks++; if (s_wr !== 1'b0) begin failures++; $display("FAIL rd_swr got=%b exp=%b", s_wr, 1'b0); end
        checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL rd_rvalid_early got=%b exp=%b", m_rvalid, 2'b00); end
        @(negedge clk);
        checks++; if (m_din !== 64'hA5A5) begin failures++; $display("FAIL rd_din got=%h exp=%h", m_din, 64'hA5A5); end
        checks++; if (m_rvalid !== 2'b01) begin failures++; $display("FAIL rd_rvalid got=%b exp=%b", m_rvalid, 2'b01); end
        checks++; if (m_err !== 2'b00) begin failures++; $display("FAIL rd_err got=%b exp=%b", m_err, 2'b00); end
        m0_addr = 16'h0021;
        @(negedge clk);
        checks++; if (m_rvalid !== 2'b01) begin failures++; $display("FAIL rd2_rvalid got=%b exp=%b", m_rvalid, 2'b01); end
        checks++; if (m_din !== 64'h2222) begin failures++; $display("FAIL rd2_din got=%h exp=%h", m_din, 64'h2222); end
        m_req = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL rd_rvalid_end got=%b exp=%b", m_rvalid, 2'b00); end
        checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL rd_grant_end got=%b exp=%b", m_grant, 2'b00); end
        // request for one cycle only: grant rises but no transfer follows
        m_req = 2'b01;
        @(negedge clk);
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL drop_grant got=%b exp=%b", m_grant, 2'b01); end
        m_req = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL drop_rvalid got=%b exp=%b", m_rvalid, 2'b00); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        @(negedge clk);
        m_req = 2'b11;
        @(negedge clk);
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=%b", m_grant, 2'b01); end
        m_req = 2'b10;
        @(negedge clk);
        checks++; if (m_grant !== 2'b10) begin failures++; $display("FAIL rr_handover got=%b exp=%b", m_grant, 2'b10); end
        m_req = 2'b00;
        @(negedge clk);
        checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL rr_idle got=%b exp=%b", m_grant, 2'b00); end
        m_req = 2'b11;
        @(negedge clk);
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL rr_second got=%b exp=%b", m_grant, 2'b01); end
        m_req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_hold_limit();
        apply_reset();
        @(negedge clk);
        m_req = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (h_grant !== 2'b01) begin failures++; $display("FAIL hold_keep cyc=%0d got=%b exp=%b", c, h_grant, 2'b01); end
        end
        @(negedge clk);
        checks++; if (h_grant !== 2'b10) begin failures++; $display("FAIL hold_force got=%b exp=%b", h_grant, 2'b10); end
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL nohold_keep got=%b exp=%b", m_grant, 2'b01); end
        apply_reset();
        @(negedge clk);
        m_req = 2'b01;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (h_grant !== 2'b01) begin failures++; $display("FAIL hold_alone cyc=%0d got=%b exp=%b", c, h_grant, 2'b01); end
        end
        m_req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_decode_err();
        apply_reset();
        @(negedge clk);
        m_req = 2'b10; m_wr = 2'b00; m1_addr = 16'h0080;
        @(negedge clk);
        checks++; if (m_grant !== 2'b10) begin failures++; $display("FAIL derr_grant got=%b exp=%b", m_grant, 2'b10); end
        checks++; if (s_sel !== 4'b0000) begin failures++; $display("FAIL derr_sel got=%b exp=%b", s_sel, 4'b0000); end
        @(negedge clk);
        checks++; if (m_err !== 2'b10) begin failures++; $display("FAIL derr_err got=%b exp=%b", m_err, 2'b10); end
        checks++; if (m_rvalid !== 2'b10) begin failures++; $display("FAIL derr_rvalid got=%b exp=%b", m_rvalid, 2'b10); end
        checks++; if (m_din !== 64'h0) begin failures++; $display("FAIL derr_din got=%h exp=%h", m_din, 64'h0); end
        m_wr = 2'b10;
        #1;
        checks++; if (s_wr !== 1'b0) begin failures++; $display("FAIL derr_wr_swr got=%b exp=%b", s_wr, 1'b0); end
        @(negedge clk);
        checks++; if (m_err !== 2'b10) begin failures++; $display("FAIL derr_wr_err got=%b exp=%b", m_err, 2'b10); end
        checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL derr_wr_rvalid got=%b exp=%b", m_rvalid, 2'b00); end
        m_req = 2'b00; m_wr = 2'b00;
        @(negedge clk);
        checks++; if (m_err !== 2'b00) begin failures++; $display("FAIL derr_end got=%b exp=%b", m_err, 2'b00); end
    endtask

    task automatic test_write();
        @(negedge clk);
        m_req = 2'b10; m_wr = 2'b10; m1_addr = 16'h0023; m1_dout = 64'h1234;
        @(negedge clk);
        checks++; if (m_grant !== 2'b10) begin failures++; $display("FAIL wr_grant got=%b exp=%b", m_grant, 2'b10); end
        checks++; if (s_wr !== 1'b1) begin failures++; $display("FAIL wr_swr got=%b exp=%b", s_wr, 1'b1); end
        checks++; if (s_sel !== 4'b0010) begin failures++; $display("FAIL wr_sel got=%b exp=%b", s_sel, 4'b0010); end
        checks++; if (s_din !== 64'h1234) begin failures++; $display("FAIL wr_sdin got=%h exp=%h", s_din, 64'h1234); end
        checks++; if (s_addr !== 16'h0023) begin failures++; $display("FAIL wr_saddr got=%h exp=%h", s_addr, 16'h0023); end
        m_req = 2'b00; m_wr = 2'b00;
        @(negedge clk);
        checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL wr_rvalid got=%b exp=%b", m_rvalid, 2'b00); end
        checks++; if (m_err !== 2'b00) begin failures++; $display("FAIL wr_err got=%b exp=%b", m_err, 2'b00); end
        checks++; if (s_din !== 64'h0) begin failures++; $display("FAIL wr_sdin_idle got=%h exp=%h", s_din, 64'h0); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        m_req = 2'b01; m_wr = 2'b00; m0_addr = 16'h0041;
        @(negedge clk);
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL mid_grant got=%b exp=%b", m_grant, 2'b01); end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        m_req = 2'b00;
        #1;
        checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL mid_grant_drop got=%b exp=%b", m_grant, 2'b00); end
        checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL mid_rvalid got=%b exp=%b", m_rvalid, 2'b00); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL mid_rvalid_after cyc=%0d got=%b exp=%b", c, m_rvalid, 2'b00); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        clear_inputs();
        set_slaves();
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold_limit();
        test_decode_err();
        test_write();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
